// File: rtl/leddc_pwm_engine.sv
// leddc_pwm_engine: double-buffered grayscale frame store driving CH PWM
// outputs, one Vsync-framed scanline window (2^GW slots) at a time, in
// conventional or scrambled multi-segment PWM.
module leddc_pwm_engine #(
  parameter int CH       = 16,
  parameter int GW       = 16,
  parameter int SCAN     = 32,
  parameter int SEG_BITS = 4,
  parameter int AW       = $clog2(SCAN*CH)
) (
  input  logic                    GCK,
  input  logic                    rst,
  input  logic                    Vsync,
  input  logic                    mode,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [GW-1:0]           wr_data,
  input  logic                    swap_req,
  output logic [CH-1:0]           OUT,
  output logic [$clog2(SCAN)-1:0] scan_idx,
  output logic                    bank,
  output logic                    frame_done
);

  localparam int SW    = $clog2(SCAN);
  localparam int OW    = GW - SEG_BITS;
  localparam int WORDS = SCAN * CH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state, state_nxt;
  logic          v_d;
  logic          edge_det;
  logic          start;
  logic          abort;
  logic          last_slot;
  logic          done;
  logic          wrap;
  logic          swap_pend;
  logic          vld_p1;
  logic          mode_p1;
  logic [GW-1:0] cnt_p1;
  logic [GW-1:0] gs_p1 [CH];
  logic [GW-1:0] mem [2][WORDS];

  // Slot decision. Mode 1 spreads the on-time over 2^SEG_BITS segments:
  // every segment gets hi slots, the first lo segments get one extra, so the
  // window total is still exactly g.
  function automatic logic slot_on(input logic [GW-1:0] n,
                                   input logic [GW-1:0] g,
                                   input logic          m);
    logic [SEG_BITS-1:0] seg;
    logic [SEG_BITS-1:0] lo;
    logic [OW-1:0]       off;
    logic [OW-1:0]       hi;
    logic [OW:0]         thr;
    seg = n[GW-1 -: SEG_BITS];
    off = n[OW-1:0];
    hi  = g[GW-1 -: OW];
    lo  = g[SEG_BITS-1:0];
    thr = {1'b0, hi} + {{OW{1'b0}}, (seg < lo)};
    if (m)
      return ({1'b0, off} < thr);
    else
      return (n < g);
  endfunction

  assign edge_det  = Vsync & ~v_d;
  assign start     = edge_det & ~vld_p1;
  assign abort     = vld_p1 & ~Vsync;
  assign last_slot = (cnt_p1 == {GW{1'b1}});
  assign done      = vld_p1 & Vsync & last_slot;
  assign wrap      = done & (scan_idx == SW'(SCAN - 1));

  // Window state register
  always_ff @(posedge GCK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Window next state: open on an idle edge, close on the last slot or abort
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (abort || last_slot) state_nxt = S_IDLE;
    endcase
  end

  // Window state decode
  always_comb begin
    vld_p1 = (state == S_RUN);
  end

  // Back-bank write port and scanline capture; storage is never reset
  always_ff @(posedge GCK) begin
    if (wr_en && (int'(wr_addr) < WORDS))
      mem[~bank][wr_addr] <= wr_data;
    // p0 -> p1: capture the front-bank scanline and the mode at the edge
    if (start) begin
      mode_p1 <= mode;
      for (int k = 0; k < CH; k++)
        gs_p1[k] <= mem[bank][AW'(int'(scan_idx) * CH + k)];
    end
  end

  // Control: edge detect, slot counter, scanline/bank sequencing, outputs
  always_ff @(posedge GCK) begin
    if (rst) begin
      v_d        <= 1'b0;
      cnt_p1     <= '0;
      scan_idx   <= '0;
      bank       <= 1'b0;
      swap_pend  <= 1'b0;
      frame_done <= 1'b0;
      OUT        <= '0;
    end else begin
      v_d        <= Vsync;
      frame_done <= wrap;
      if (start)
        cnt_p1 <= '0;
      else if (vld_p1)
        cnt_p1 <= cnt_p1 + 1'b1;
      if (done)
        scan_idx <= wrap ? '0 : scan_idx + 1'b1;
      // A request arriving in the wrap cycle itself still takes this wrap
      if (wrap) begin
        bank      <= bank ^ (swap_pend | swap_req);
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
      // p1 -> p2: registered slot decision; an abort blanks it immediately
      for (int k = 0; k < CH; k++)
        OUT[k] <= (vld_p1 && Vsync) ? slot_on(cnt_p1, gs_p1[k], mode_p1) : 1'b0;
    end
  end

endmodule

// File: tb/tb_leddc_pwm_engine.sv
// Bench for leddc_pwm_engine (CH=4, GW=8, SCAN=4, SEG_BITS=2): directed
// window sequence with random frame contents, checked against a count-based
// model of the displayed frame.
module tb_leddc_pwm_engine;

  localparam int CH       = 4;
  localparam int GW       = 8;
  localparam int SCAN     = 4;
  localparam int SEG_BITS = 2;
  localparam int AW       = 4;
  localparam int SLOTS    = 256;

  logic          GCK = 1'b0;
  logic          rst;
  logic          Vsync;
  logic          mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [GW-1:0] wr_data;
  logic          swap_req;
  logic [CH-1:0] OUT;
  logic [1:0]    scan_idx;
  logic          bank;
  logic          frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int win      = 0;

  logic [7:0] ref_mem   [2][16];
  bit         ref_known [2][16];
  int         ref_scan;
  bit         ref_bank;
  bit         ref_pend;

  leddc_pwm_engine #(.CH(CH), .GW(GW), .SCAN(SCAN), .SEG_BITS(SEG_BITS)) dut (
    .GCK(GCK), .rst(rst), .Vsync(Vsync), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req), .OUT(OUT),
    .scan_idx(scan_idx), .bank(bank), .frame_done(frame_done)
  );

  always #5 GCK = ~GCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge GCK); #1;
  endtask

  task automatic write_word(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    ref_mem[ref_bank ^ 1'b1][a]   = d;
    ref_known[ref_bank ^ 1'b1][a] = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; ref_pend = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  // One scanline window. Entered with Vsync already low in the current cycle;
  // leaves Vsync low in the cycle after the last slot so that the next call
  // produces a back-to-back edge.
  task automatic run_window(input bit m, input int abort_slot, input int swap_at,
                            input int wr_at, input int wr_a, input logic [7:0] wr_d);
    logic [255:0] pat [CH];
    logic [7:0]   g [CH];
    logic [255:0] one256;
    logic [64:0]  one65;
    logic [64:0]  mask65;
    logic [63:0]  segbits;
    bit           known;
    bit           wrap_exp;
    int           fd_cnt, fd_at, exp_c;
    known = 1'b1;
    for (int k = 0; k < CH; k++) begin
      g[k]  = ref_mem[ref_bank][ref_scan*CH + k];
      known = known & ref_known[ref_bank][ref_scan*CH + k];
      pat[k] = '0;
    end
    wrap_exp = (ref_scan == SCAN-1);
    tick();
    check($sformatf("w%0d_idle_out", win), OUT, 0);
    check($sformatf("w%0d_scan_pre", win), scan_idx, ref_scan);
    Vsync = 1'b1; mode = m;
    tick();
    mode = 1'($urandom);
    fd_cnt = 0; fd_at = -1;
    for (int n = 0; n < SLOTS; n++) begin
      tick();
      swap_req = 1'b0; wr_en = 1'b0;
      for (int k = 0; k < CH; k++) pat[k][n] = OUT[k];
      if (frame_done) begin fd_cnt++; fd_at = n; end
      if (n == abort_slot) begin
        Vsync = 1'b0;
        tick();
        tick();
        check($sformatf("w%0d_abort_out", win), OUT, 0);
        check($sformatf("w%0d_abort_scan", win), scan_idx, ref_scan);
        check($sformatf("w%0d_abort_fd", win), fd_cnt, 0);
        win++;
        return;
      end
      if (n == swap_at) begin swap_req = 1'b1; ref_pend = 1'b1; end
      if (n == wr_at) begin
        wr_en = 1'b1; wr_addr = AW'(wr_a); wr_data = wr_d;
        ref_mem[ref_bank ^ 1'b1][wr_a]   = wr_d;
        ref_known[ref_bank ^ 1'b1][wr_a] = 1'b1;
      end
      if (n == SLOTS-2) begin
        if (wrap_exp) begin
          if (ref_pend) ref_bank = ref_bank ^ 1'b1;
          ref_pend = 1'b0;
        end
        ref_scan = (ref_scan + 1) % SCAN;
      end
      if (n == SLOTS-1) Vsync = 1'b0;
    end
    check($sformatf("w%0d_scan_post", win), scan_idx, ref_scan);
    check($sformatf("w%0d_bank", win), bank, ref_bank);
    check($sformatf("w%0d_fd_count", win), fd_cnt, wrap_exp ? 1 : 0);
    if (wrap_exp) check($sformatf("w%0d_fd_slot", win), fd_at, SLOTS-1);
    if (known) begin
      one256 = 1;
      one65  = 1;
      for (int k = 0; k < CH; k++) begin
        check($sformatf("w%0d_count_ch%0d", win, k), $countones(pat[k]), g[k]);
        if (!m) begin
          check($sformatf("w%0d_m0_shape_ch%0d", win, k), pat[k], (one256 << g[k]) - 1);
        end else begin
          for (int s = 0; s < 4; s++) begin
            exp_c   = int'(g[k] >> 2) + ((s < int'(g[k] & 8'd3)) ? 1 : 0);
            segbits = pat[k][s*64 +: 64];
            mask65  = (one65 << exp_c) - 1;
            check($sformatf("w%0d_m1_seg%0d_ch%0d", win, s, k), segbits, mask65[63:0]);
          end
        end
      end
    end
    win++;
  endtask

  initial begin
    rst = 1'b1; Vsync = 1'b0; mode = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) begin ref_known[b][a] = 1'b0; ref_mem[b][a] = '0; end
    ref_scan = 0; ref_bank = 1'b0; ref_pend = 1'b0;

    // Power-on reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out", OUT, 0);
    check("rst_scan", scan_idx, 0);
    check("rst_bank", bank, 0);
    check("rst_fd", frame_done, 0);

    // Reset held two cycles in the middle of a window
    Vsync = 1'b1;
    repeat (50) tick();
    rst = 1'b1; Vsync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rstmid_out", OUT, 0);
    check("rstmid_scan", scan_idx, 0);
    check("rstmid_bank", bank, 0);
    check("rstmid_fd", frame_done, 0);
    ref_scan = 0; ref_bank = 1'b0; ref_pend = 1'b0;

    // Fill the back bank: directed scanlines 0/1, random elsewhere
    for (int a = 0; a < 16; a++) begin
      case (a)
        0:       write_word(a, 8'h00);
        1:       write_word(a, 8'h01);
        2:       write_word(a, 8'h80);
        3:       write_word(a, 8'hFF);
        4:       write_word(a, 8'h45);
        5:       write_word(a, 8'hFF);
        default: write_word(a, 8'($urandom_range(0, 255)));
      endcase
    end
    pulse_swap();

    // First frame shows the never-written bank; only sequencing is checked
    repeat (4) run_window(1'b0, -1, -1, -1, 0, 8'h00);
    check("bank_after_frame0", bank, 1);

    // Mode 0 directed scanline 0
    run_window(1'b0, -1, -1, -1, 0, 8'h00);

    // Fill the other bank with random data
    for (int a = 0; a < 16; a++) write_word(a, 8'($urandom_range(0, 255)));

    // Mode 1 directed scanline 1, swap requested mid-frame
    run_window(1'b1, -1, 30, -1, 0, 8'h00);
    // Second request while pending; scanline 2 still on the old bank
    run_window(1'($urandom), -1, 100, -1, 0, 8'h00);
    // Scanline 3 with a write in the wrap cycle, landing in the new front bank
    run_window(1'b0, -1, -1, SLOTS-2, 0, 8'h3C);
    run_window(1'b1, -1, -1, -1, 0, 8'h00);

    // Abort at slot 100 on scanline 1, then replay it
    run_window(1'b0, 100, -1, -1, 0, 8'h00);
    run_window(1'b0, -1, -1, -1, 0, 8'h00);

    // Back-to-back windows, swap requested in the wrap cycle itself
    run_window(1'($urandom), -1, -1, -1, 0, 8'h00);
    run_window(1'($urandom), -1, SLOTS-2, -1, 0, 8'h00);
    run_window(1'($urandom), -1, -1, -1, 0, 8'h00);
    run_window(1'($urandom), -1, -1, -1, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
